// File: rtl/seg7_pkg.sv
// Shared constants for 7-segment display blocks: widths, segment bit order,
// the hex glyph table and the sample classification used by the scan capture.
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int NDIG  = 4;

    // Segment vectors are ordered {a,b,c,d,e,f,g}: segment a is the MSB, g the LSB.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F = 7'h47;

    typedef enum logic [1:0] {
        SAMPLE_BLANK  = 2'd0,
        SAMPLE_NORMAL = 2'd1,
        SAMPLE_GLITCH = 2'd2
    } sample_kind_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to hex nibble decoder; legal is low for
// any pattern that is not one of the sixteen hex glyphs.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pat,
    output logic [3:0]       nibble,
    output logic             legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (pat)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the nibble shown on each position of a multiplexed 4-digit
// 7-segment display by watching its select and segment lines.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE         = 4,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       s0,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] valid,
    output logic [3:0] code_err,
    output logic       glitch,
    output logic       frame_done
);

    localparam logic [7:0]       SETTLE_CNT = 8'(SETTLE);
    localparam logic [NDIG-1:0]  SEL_INV    = {NDIG{SEL_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0] SEG_INV    = {SEG_W{SEG_ACTIVE_LOW}};

    logic [NDIG-1:0]       sel_raw, sel_meta, sel;
    logic [SEG_W-1:0]      pat_raw, pat_meta, pat;
    logic [NDIG+SEG_W-1:0] sample, prev_sample;
    logic [7:0]            cnt, cnt_next;
    logic                  captured, captured_next, cap_clr, cap_fire;
    sample_kind_t          kind;
    logic [3:0]            dec_nibble;
    logic                  dec_legal;
    logic [NDIG-1:0]       frame_mask, mask_next;
    logic [3:0]            digit_q [NDIG];

    assign sel_raw = {s3, s2, s1, s0};
    assign pat_raw = {a, b, c, d, e, f, g};
    assign sample  = {sel, pat};

    assign digit0 = digit_q[0];
    assign digit1 = digit_q[1];
    assign digit2 = digit_q[2];
    assign digit3 = digit_q[3];

    seg7_to_hex u_dec (
        .pat    (pat),
        .nibble (dec_nibble),
        .legal  (dec_legal)
    );

    always_comb begin
        if (sel == '0)
            kind = SAMPLE_BLANK;
        else if ((sel & (sel - 4'd1)) != '0)
            kind = SAMPLE_GLITCH;
        else
            kind = SAMPLE_NORMAL;
    end

    // The counter value seen on the capture edge is cnt_next, which makes the
    // capture land 2 + SETTLE cycles after an input change.
    always_comb begin
        cnt_next      = '0;
        captured_next = captured;
        cap_clr       = (kind == SAMPLE_BLANK) || (sel != prev_sample[SEG_W +: NDIG]);
        if (kind == SAMPLE_NORMAL) begin
            if (sample == prev_sample)
                cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            else
                cnt_next = 8'd1;
        end
        cap_fire = (kind == SAMPLE_NORMAL) && (cnt_next == SETTLE_CNT) &&
                   (!captured || cap_clr);
        if (cap_fire)
            captured_next = 1'b1;
        else if (cap_clr)
            captured_next = 1'b0;
        mask_next = frame_mask | (cap_fire ? sel : '0);
    end

    // Inputs are normalized to active-high before the first flop so the
    // cleared synchronizer reads as a blank sample rather than a glitch.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sel_meta    <= '0;
            sel         <= '0;
            pat_meta    <= '0;
            pat         <= '0;
            prev_sample <= '0;
            cnt         <= '0;
            captured    <= 1'b0;
            frame_mask  <= '0;
            valid       <= '0;
            code_err    <= '0;
            glitch      <= 1'b0;
            frame_done  <= 1'b0;
            for (int i = 0; i < NDIG; i++)
                digit_q[i] <= '0;
        end else begin
            sel_meta    <= sel_raw ^ SEL_INV;
            sel         <= sel_meta;
            pat_meta    <= pat_raw ^ SEG_INV;
            pat         <= pat_meta;
            prev_sample <= sample;
            cnt         <= cnt_next;
            captured    <= captured_next;
            glitch      <= (kind == SAMPLE_GLITCH);
            if (cap_fire) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (sel[i]) begin
                        if (dec_legal) begin
                            digit_q[i]  <= dec_nibble;
                            valid[i]    <= 1'b1;
                            code_err[i] <= 1'b0;
                        end else begin
                            valid[i]    <= 1'b0;
                            code_err[i] <= 1'b1;
                        end
                    end
                end
            end
            if (mask_next == '1) begin
                frame_done <= 1'b1;
                frame_mask <= '0;
            end else begin
                frame_done <= 1'b0;
                frame_mask <= mask_next;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: vector table, hand-written corner sequences and
// randomized scans checked every cycle against a behavioural model.
module tb_seg7_scan_capture;

    localparam int SETTLE = 4;

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  pat;
        int          hold;
        logic [15:0] exp_digits;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_err;
        int          exp_fd;
    } vec_t;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic s0 = 1'b1, s1 = 1'b1, s2 = 1'b1, s3 = 1'b1;
    logic a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1, e = 1'b1, f = 1'b1, g = 1'b1;
    logic [3:0] digit0, digit1, digit2, digit3, valid, code_err;
    logic glitch, frame_done;

    logic p_s0 = 1'b0, p_s1 = 1'b0, p_s2 = 1'b0, p_s3 = 1'b0;
    logic p_a = 1'b0, p_b = 1'b0, p_c = 1'b0, p_d = 1'b0, p_e = 1'b0, p_f = 1'b0, p_g = 1'b0;
    logic [3:0] p_digit0, p_digit1, p_digit2, p_digit3, p_valid, p_code_err;
    logic p_glitch, p_frame_done;

    int checks = 0;
    int failures = 0;
    int fd_seen = 0;
    int gl_seen = 0;
    bit model_on = 1'b0;

    // Behavioural model state
    logic [10:0] pipe_q[$];
    logic [6:0]  seg_tab[16];
    logic [3:0]  m_dig[4];
    logic [3:0]  m_valid, m_err, m_mask;
    logic        m_glitch, m_fd, m_cap;
    logic [10:0] m_prev;
    int          m_run;

    vec_t vecs[22];

    always #5 Clock = ~Clock;

    seg7_scan_capture #(.SETTLE(SETTLE), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .valid(valid), .code_err(code_err), .glitch(glitch), .frame_done(frame_done)
    );

    seg7_scan_capture #(.SETTLE(SETTLE), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_pol (
        .Clock(Clock), .Resetn(Resetn),
        .s0(p_s0), .s1(p_s1), .s2(p_s2), .s3(p_s3),
        .a(p_a), .b(p_b), .c(p_c), .d(p_d), .e(p_e), .f(p_f), .g(p_g),
        .digit0(p_digit0), .digit1(p_digit1), .digit2(p_digit2), .digit3(p_digit3),
        .valid(p_valid), .code_err(p_code_err), .glitch(p_glitch), .frame_done(p_frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {6'd0, digit3, digit2, digit1, digit0, valid, code_err, glitch, frame_done};
    endfunction

    function automatic logic [31:0] model_vec();
        return {6'd0, m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, m_err, m_glitch, m_fd};
    endfunction

    // Applies the spec rules to one synchronized sample (two edges behind the pins).
    task automatic model_edge(input logic [10:0] smp_in, input logic rstn);
        logic [10:0] smp;
        logic [3:0]  ssel;
        int          ones, pos, hexv;
        if (!rstn) begin
            pipe_q.delete();
            pipe_q.push_back(11'd0);
            pipe_q.push_back(11'd0);
            m_run = 0; m_cap = 1'b0; m_prev = '0;
            m_valid = '0; m_err = '0; m_mask = '0; m_glitch = 1'b0; m_fd = 1'b0;
            for (int k = 0; k < 4; k++) m_dig[k] = '0;
        end else begin
            pipe_q.push_back(smp_in);
            smp = pipe_q.pop_front();
            ssel = smp[10:7];
            ones = $countones(ssel);
            m_glitch = (ones > 1);
            m_fd = 1'b0;
            if (ones == 0) begin
                m_run = 0;
                m_cap = 1'b0;
            end else if (ones > 1) begin
                m_run = 0;
                if (ssel != m_prev[10:7]) m_cap = 1'b0;
            end else begin
                m_run = (smp == m_prev) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                if (ssel != m_prev[10:7]) m_cap = 1'b0;
                if (m_run == SETTLE && !m_cap) begin
                    m_cap = 1'b1;
                    pos = 0;
                    for (int k = 0; k < 4; k++) if (ssel[k]) pos = k;
                    hexv = -1;
                    for (int h = 0; h < 16; h++) if (seg_tab[h] == smp[6:0]) hexv = h;
                    if (hexv >= 0) begin
                        m_dig[pos] = hexv[3:0];
                        m_valid[pos] = 1'b1;
                        m_err[pos] = 1'b0;
                    end else begin
                        m_valid[pos] = 1'b0;
                        m_err[pos] = 1'b1;
                    end
                    m_mask[pos] = 1'b1;
                    if (m_mask == 4'hF) begin
                        m_fd = 1'b1;
                        m_mask = '0;
                    end
                end
            end
            m_prev = smp;
        end
    endtask

    task automatic step(input logic [3:0] sel, input logic [6:0] pat, input logic rstn);
        @(negedge Clock);
        {s3, s2, s1, s0} = ~sel;
        {a, b, c, d, e, f, g} = ~pat;
        Resetn = rstn;
        @(posedge Clock);
        if (!rstn) model_on = 1'b1;
        if (model_on) model_edge({sel, pat}, rstn);
        #1;
        if (frame_done === 1'b1) fd_seen++;
        if (glitch === 1'b1) gl_seen++;
        if (model_on) check($sformatf("cycle@%0t", $time), dut_vec(), model_vec());
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] pat, input int n);
        for (int k = 0; k < n; k++) step(sel, pat, 1'b1);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        int fd0;
        for (int i = lo; i <= hi; i++) begin
            fd0 = fd_seen;
            hold(vecs[i].sel, vecs[i].pat, vecs[i].hold);
            check($sformatf("vec%0d_digits", i), {16'd0, digit3, digit2, digit1, digit0}, {16'd0, vecs[i].exp_digits});
            check($sformatf("vec%0d_valid", i), {28'd0, valid}, {28'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_code_err", i), {28'd0, code_err}, {28'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_frame_done", i), fd_seen - fd0, vecs[i].exp_fd);
        end
    endtask

    initial begin
        #1ms;
        failures++;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int fd0, gl0, r, n;
        logic [3:0] rsel;
        logic [6:0] rpat;

        seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

        vecs[0]  = '{4'b0000, 7'h00, 3,  16'h0002, 4'b0001, 4'b0000, 0};
        vecs[1]  = '{4'b0001, 7'h7E, 15, 16'h0000, 4'b0001, 4'b0000, 0};
        vecs[2]  = '{4'b0010, 7'h30, 15, 16'h0010, 4'b0011, 4'b0000, 0};
        vecs[3]  = '{4'b0100, 7'h77, 15, 16'h0A10, 4'b0111, 4'b0000, 0};
        vecs[4]  = '{4'b1000, 7'h47, 15, 16'hFA10, 4'b1111, 4'b0000, 1};
        vecs[5]  = '{4'b0000, 7'h00, 3,  16'hFA10, 4'b1111, 4'b0000, 0};
        vecs[6]  = '{4'b0100, 7'h01, 10, 16'hFA10, 4'b1011, 4'b0100, 0};
        vecs[7]  = '{4'b0000, 7'h00, 3,  16'hFA10, 4'b1011, 4'b0100, 0};
        vecs[8]  = '{4'b0100, 7'h4F, 10, 16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[9]  = '{4'b0000, 7'h00, 3,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[10] = '{4'b0010, 7'h33, 2,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[11] = '{4'b0010, 7'h7F, 2,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[12] = '{4'b0010, 7'h33, 2,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[13] = '{4'b0000, 7'h00, 6,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[14] = '{4'b0001, 7'h7E, 8,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[15] = '{4'b1000, 7'h47, 8,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[16] = '{4'b0010, 7'h30, 8,  16'hFE10, 4'b1111, 4'b0000, 1};
        vecs[17] = '{4'b0000, 7'h00, 3,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[18] = '{4'b0010, 7'h30, 8,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[19] = '{4'b0001, 7'h7E, 8,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[20] = '{4'b0100, 7'h4F, 8,  16'hFE10, 4'b1111, 4'b0000, 0};
        vecs[21] = '{4'b1000, 7'h47, 8,  16'hFE10, 4'b1111, 4'b0000, 1};

        // Reset with random pin activity
        for (int i = 0; i < 3; i++) begin
            step(4'($urandom), 7'($urandom), 1'b0);
            check($sformatf("reset_outputs%0d", i), dut_vec(), 32'd0);
        end
        hold(4'b0000, 7'h00, 4);

        // Single digit: capture lands exactly 2 + SETTLE cycles after the change
        fd0 = fd_seen;
        for (int i = 1; i <= 20; i++) begin
            step(4'b0001, 7'h6D, 1'b1);
            check($sformatf("single_valid_c%0d", i), {28'd0, valid}, (i >= 2 + SETTLE) ? 32'd1 : 32'd0);
            check($sformatf("single_digit0_c%0d", i), {28'd0, digit0}, (i >= 2 + SETTLE) ? 32'd2 : 32'd0);
        end
        check("single_frame_done", fd_seen - fd0, 0);

        // Full scan, illegal pattern, short bounce
        run_vectors(0, 13);

        // Two selects at once: glitch, no capture
        fd0 = fd_seen;
        gl0 = gl_seen;
        hold(4'b1010, 7'h7E, 8);
        hold(4'b0000, 7'h00, 4);
        check("glitch_seen", {31'd0, gl_seen > gl0}, 32'd1);
        check("glitch_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FE10);
        check("glitch_valid", {28'd0, valid}, 32'hF);
        check("glitch_frame_done", fd_seen - fd0, 0);

        // Blank-separated identical s1 intervals must both capture
        run_vectors(14, 21);

        // Active-high polarity instance
        check("pol_reset_valid", {28'd0, p_valid}, 32'd0);
        @(negedge Clock);
        p_s3 = 1'b1;
        {p_a, p_b, p_c, p_d, p_e, p_f, p_g} = 7'h5B;
        hold(4'b0000, 7'h00, 12);
        check("pol_digit3", {28'd0, p_digit3}, 32'd5);
        check("pol_valid", {28'd0, p_valid}, 32'h8);
        check("pol_code_err", {28'd0, p_code_err}, 32'd0);

        // Reset in the middle of a settle interval
        hold(4'b0001, 7'h5B, 4);
        for (int i = 0; i < 2; i++) begin
            step(4'($urandom), 7'($urandom), 1'b0);
            check($sformatf("midreset_outputs%0d", i), dut_vec(), 32'd0);
        end
        check("midreset_pol_valid", {28'd0, p_valid}, 32'd0);
        hold(4'b0000, 7'h00, 3);

        // Randomized scans checked cycle by cycle against the model
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                rsel = 4'b0000;
            end else if (r == 2) begin
                do rsel = 4'($urandom); while ($countones(rsel) < 2);
            end else begin
                rsel = 4'b0001 << $urandom_range(0, 3);
            end
            if ($urandom_range(0, 3) != 0)
                rpat = seg_tab[$urandom_range(0, 15)];
            else
                rpat = 7'($urandom);
            n = $urandom_range(1, 12);
            hold(rsel, rpat, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
